// File: rtl/fetch_unit.sv
// WISC instruction fetch stage: owns the PC, drives the multi-cycle instruction
// memory, holds each fetched instruction until decode accepts it, squashes on redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        squash_q, squash_d;
    logic        err_q, err_d;
    logic        go_q, go_d;

    logic        fetch_active;
    logic        done_live;
    logic        accept;
    logic        fault;

    // go_q keeps the request line low for the first cycle after reset.
    assign fetch_active = (state_q == S_FETCH) && go_q;
    assign done_live    = fetch_active && imem_done;
    assign accept       = (state_q == S_VALID) && !stall && !branch_taken;
    assign fault        = (done_live && imem_err && !squash_q)
                        || (branch_taken && branch_target[0]);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        pcp2_d     = pcp2_q;
        squash_d   = squash_q;
        err_d      = err_q;
        go_d       = 1'b1;

        if (state_q != S_HALT) begin
            if (fault) begin
                err_d    = 1'b1;
                state_d  = S_HALT;
                instr_d  = NOP_INSTR;
                squash_d = 1'b0;
            end else if (branch_taken) begin
                pc_d    = branch_target;
                state_d = S_FETCH;
                instr_d = NOP_INSTR;
                // Only an in-flight request with no completion this cycle needs squashing.
                if ((state_q == S_VALID) || done_live || !go_q) begin
                    req_addr_d = branch_target;
                    squash_d   = 1'b0;
                end else begin
                    squash_d = 1'b1;
                end
            end else if (accept) begin
                instr_d = NOP_INSTR;
                if (instr_q[15:11] == 5'b00000) begin
                    state_d = S_HALT;
                end else begin
                    state_d    = S_FETCH;
                    req_addr_d = pc_q;
                end
            end else if (done_live) begin
                if (squash_q) begin
                    squash_d   = 1'b0;
                    req_addr_d = pc_q;
                end else begin
                    instr_d = imem_data;
                    pcp2_d  = req_addr_q + 16'd2;
                    pc_d    = req_addr_q + 16'd2;
                    state_d = S_VALID;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcp2_q     <= 16'h0000;
            squash_q   <= 1'b0;
            err_q      <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pcp2_q     <= pcp2_d;
            squash_q   <= squash_d;
            err_q      <= err_d;
            go_q       <= go_d;
        end
    end

    assign imem_rd     = fetch_active;
    assign imem_addr   = req_addr_q;
    assign instr       = instr_q;
    assign pc_plus2    = pcp2_q;
    assign instr_valid = (state_q == S_VALID);
    assign halted      = (state_q == S_HALT);
    assign err         = err_q;

endmodule
